web_rx_decoder: RTL and testbench

Receive-side counterpart of the web interface processing path. It consumes the one-cycle `valid`-qualified byte stream produced by the web interface FSM and removes the +0x20 encoding offset. It checks the producer's minimum pulse spacing, buffers decoded bytes in a small FIFO, and presents them downstream on a ready/valid handshake. It sits between the web interface output and the response consumer logic.

---
 rtl/web_pkg.sv | 18 +
 rtl/web_sync_fifo.sv | 64 ++++++
 rtl/web_rx_decoder.sv | 123 ++++++++++++
 tb/tb_web_rx_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/web_pkg.sv
`default_nettype none
// ============================================================================
// web_pkg : shared constants and types for the web interface byte path
// Rev 1.0
// ============================================================================
package web_pkg;

  localparam logic [7:0] WEB_OFFSET  = 8'h20;
  localparam int         WEB_MIN_GAP = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    READY   = 2'd2
  } rx_gap_state_t;

endpackage
`default_nettype wire

// File: rtl/web_sync_fifo.sv
`default_nettype none
// ============================================================================
// web_sync_fifo : single-clock FIFO with wrap-bit pointers and occupancy
// Rev 1.0
// ============================================================================
module web_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO is allowed only when the head leaves this cycle
  assign w_rd = rd_en_i && !w_empty;
  assign w_wr = wr_en_i && (!w_full || w_rd);

  assign wr_ptr_d = w_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = w_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fill_o    = wr_ptr_q - rd_ptr_q;
  assign full_o    = w_full;
  assign empty_o   = w_empty;

endmodule
`default_nettype wire

// File: rtl/web_rx_decoder.sv
`default_nettype none
// ============================================================================
// web_rx_decoder : strips the encode offset, polices pulse spacing, buffers
// decoded bytes and hands them out on ready/valid.   Rev 1.0
// ============================================================================
module web_rx_decoder
  import web_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter logic [7:0] OFFSET  = WEB_OFFSET,
  parameter int         MIN_GAP = WEB_MIN_GAP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic                   gap_err,
  input  logic                   err_clr
);

  localparam logic [3:0] c_MIN_GAP = 4'(MIN_GAP);

  rx_gap_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          gap_q, gap_d;
  logic          w_accept;
  logic          w_gap_viol;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [7:0]    w_decoded;

  assign w_decoded = in_data - OFFSET;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_accept   = 1'b0;
    w_gap_viol = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          cnt_d    = 4'd1;
          state_d  = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // Any pulse, legal or not, restarts the spacing window
        if (in_valid) begin
          cnt_d = 4'd1;
          if (cnt_q < c_MIN_GAP) begin
            w_gap_viol = 1'b1;
          end else begin
            w_accept = 1'b1;
          end
        end else if (cnt_q >= c_MIN_GAP) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READY: begin
        if (in_valid) begin
          w_accept = 1'b1;
          cnt_d    = 4'd1;
          state_d  = HOLDOFF;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_pop = !w_empty && out_ready;

  // Set wins over clear
  assign ovf_d = (w_accept && w_full && !w_pop) || (ovf_q && !err_clr);
  assign gap_d = w_gap_viol || (gap_q && !err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
    end
  end

  web_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_accept),
    .wr_data_i (w_decoded),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .fill_o    (fill),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign out_valid = !w_empty;
  assign overflow  = ovf_q;
  assign gap_err   = gap_q;

endmodule
`default_nettype wire

// File: tb/tb_web_rx_decoder.sv
`default_nettype none
// ============================================================================
// tb_web_rx_decoder : directed and random stimulus against a timestamp-based
// reference model, with a queue scoreboard drained by a monitor.   Rev 1.0
// ============================================================================
module tb_web_rx_decoder;

  localparam int         DEPTH   = 8;
  localparam int         MIN_GAP = 3;
  localparam logic [7:0] OFFSET  = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] fill;
  logic       overflow;
  logic       gap_err;

  web_rx_decoder #(
    .DEPTH   (DEPTH),
    .OFFSET  (OFFSET),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow),
    .gap_err   (gap_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         mfill = 0;
  bit         exp_ovf = 1'b0;
  bit         exp_gap = 1'b0;
  bit         seen = 1'b0;
  longint     cyc = 0;
  longint     last_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    check("fill", 32'(fill), 32'(mfill));
    check("out_valid", 32'(out_valid), 32'(mfill > 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("gap_err", 32'(gap_err), 32'(exp_gap));
  endtask

  // One clock of stimulus; the model decides what should happen at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    bit pop, legal, set_g, set_o;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    err_clr   = clr;
    pop   = (mfill > 0) && rdy;
    set_g = 1'b0;
    set_o = 1'b0;
    if (v) begin
      legal      = !seen || (cyc - last_pulse >= MIN_GAP);
      seen       = 1'b1;
      last_pulse = cyc;
      if (!legal) set_g = 1'b1;
      else if (mfill == DEPTH && !pop) set_o = 1'b1;
      else begin
        sb.push_back(8'(d - OFFSET));
        mfill++;
      end
    end
    if (pop) mfill--;
    exp_gap = set_g || (exp_gap && !clr);
    exp_ovf = set_o || (exp_ovf && !clr);
    cyc++;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic spaced(input logic [7:0] d, input logic rdy);
    step(1'b1, d, rdy, 1'b0);
    idle(MIN_GAP - 1, rdy);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    #1;
    sb.delete();
    mfill   = 0;
    seen    = 1'b0;
    exp_gap = 1'b0;
    exp_ovf = 1'b0;
    check_status();
    check("out_data_reset", 32'(out_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: whenever the DUT presents data, it must be the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'h0);
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_status();
    check("out_data_reset", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // Single byte
    idle(4, 1'b1);
    step(1'b1, 8'h61, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Legal spacing, fill to 8, then drain
    for (int i = 0; i < 8; i++) spaced(8'(8'h20 + i), 1'b0);
    idle(10, 1'b1);

    // Gap violation, later legal pulse, then clear
    step(1'b1, 8'h30, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h31, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 8'h32, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Overflow on a 9th legal pulse, then clear and drain
    for (int i = 0; i < 9; i++) spaced(8'(8'h40 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(10, 1'b1);

    // Full with a simultaneous pop on the 9th pulse
    for (int i = 0; i < 8; i++) spaced(8'(8'h50 + i), 1'b0);
    step(1'b1, 8'h58, 1'b1, 1'b0);
    idle(12, 1'b1);

    // Wrap and backpressure: ready pattern 1,0,0
    for (int i = 0; i < 60; i++)
      step(i % 3 == 0, 8'(8'h05 + 8 * (i / 3)), (i % 3) == 0, 1'b0);
    idle(24, 1'b1);

    // Reset mid-operation with 4 entries buffered
    for (int i = 0; i < 4; i++) spaced(8'(8'h70 + i), 1'b0);
    do_reset();
    step(1'b1, 8'h44, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Random traffic, loosely and heavily backpressured
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0);
    idle(12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
